sc_mul_scheduler: RTL
=====================

// Module: sc_mul_scheduler
// PURPOSE
// - Shares one stochastic-computing multiplier among N_REQ requesters.
// - Arbitrates round-robin, latches one operand pair, then clears the multiplier.
// - Waits for the multiplier to finish its bitstream, then returns the product with the requester's id.
// - Sits between the FPU mantissa-product issue logic and the multiplier instance.
// PARAMETERS
// - N_REQ      4         number of requesters, 2..8
// - REG_WIDTH  8         operand/result width; matches multiplier reg_width
// - BSL        255       multiplier bitstream length in cycles
// - TIMEOUT    BSL+8     max RUN cycles before abort (only with SC_SCHED_TIMEOUT_EN)
// PORTS
// - clk        in   1                  clock, all logic on posedge
// - rst        in   1                  reset, asynchronous, active-high
// - req_valid  in   N_REQ              per-requester operand valid
// - req_ready  out  N_REQ              per-requester accept, one-hot or zero
// - req_a      in   N_REQ*REG_WIDTH    operand a, requester i at [i*REG_WIDTH +: REG_WIDTH]
// - req_b      in   N_REQ*REG_WIDTH    operand b, same packing
// - rsp_valid  out  1                  result valid
// - rsp_ready  in   1                  result accepted
// - rsp_id     out  $clog2(N_REQ)      index of requester owning the result
// - rsp_x      out  REG_WIDTH          product count from multiplier
// - rsp_err    out  1                  timeout abort flag, valid with rsp_valid
// - mul_clr    out  1                  one-cycle clear/restart pulse to multiplier
// - mul_a      out  REG_WIDTH          operand a to multiplier, stable from CLR to RESP exit
// - mul_b      out  REG_WIDTH          operand b to multiplier, same
// - mul_done   in   1                  multiplier finished
// - mul_x      in   REG_WIDTH          multiplier accumulated result
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, rr_ptr=0, cnt=0.
//   - Outputs after reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_x=0, rsp_err=0, mul_clr=0, mul_a=0, mul_b=0.
//   - Reset mid-operation abandons the in-flight op silently; no response is produced.
// - FSM states: IDLE -> CLR -> RUN -> RESP -> IDLE.
// - IDLE:
//   - Grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready[g]=1 combinationally in the same cycle; that cycle is the handshake.
//   - On handshake: mul_a<=req_a[g], mul_b<=req_b[g], rsp_id<=g, then go to CLR.
//   - No req_valid set: stay in IDLE.
//   - req_ready=0 in every state other than IDLE.
// - CLR: mul_clr=1 for exactly one cycle, cnt<=0, then go to RUN.
// - RUN:
//   - cnt increments every cycle.
//   - mul_done is ignored while cnt==0 (stale done from the previous op).
//   - mul_done=1 with cnt>=1: rsp_x<=mul_x, rsp_err<=0, then go to RESP.
// - RESP:
//   - rsp_valid=1; rsp_id, rsp_x and rsp_err are held until rsp_valid && rsp_ready.
//   - On that handshake: rr_ptr<=(rsp_id+1) mod N_REQ, then go to IDLE.
//   - rsp_valid drops the following cycle.
// - Latency: accept to rsp_valid = 1 (CLR) + run length + 1 cycles.
//   - Run length is BSL+2 for the gen_type 0/1 multipliers.
// - Back-to-back: the next grant can occur the cycle after the RESP handshake.
//   - Throughput is one op per (latency+1) cycles minimum.
// - Fairness: a continuously requesting requester is served at least once every N_REQ ops.
// - Width: rsp_x is a straight copy of mul_x, no scaling or saturation.
// - mul_a and mul_b change only on an IDLE handshake.
// CONFIGURATION
// - SC_SCHED_TIMEOUT_EN defined:
//   - In RUN, if cnt reaches TIMEOUT without a qualifying mul_done: rsp_x<=0, rsp_err<=1, then go to RESP.
//   - mul_done and timeout in the same cycle: done wins, rsp_err=0.
// - SC_SCHED_TIMEOUT_EN undefined:
//   - No timeout logic; RUN waits indefinitely.
//   - rsp_err is tied to 0.
//   - cnt is only as wide as needed to qualify mul_done.
// TESTING
// - Single request, N_REQ=4: req 2 with a=128, b=128; model multiplier returns done at cycle 257 with x=64.
//   - Expect rsp_id=2, rsp_x=64, rsp_err=0, mul_clr pulsed exactly once.
// - All four requesting continuously with rsp_ready=1.
//   - Expect grant order 0,1,2,3,0,1, with no requester served twice before another waiting one.
// - rsp_ready held 0 for 10 cycles in RESP.
//   - Expect rsp_valid, rsp_x and rsp_id stable; req_ready stays 0 throughout; no new mul_clr.
// - mul_done held high from the previous op into the RUN cycle with cnt==0.
//   - Expect it ignored; the result is captured only on a later done.
// - Assert rst mid-RUN (cnt=100).
//   - Expect immediate return to reset output values, rr_ptr=0, and no rsp_valid afterwards until a new request completes.
// - SC_SCHED_TIMEOUT_EN with mul_done never asserted.
//   - Expect rsp_valid with rsp_err=1 and rsp_x=0 exactly TIMEOUT cycles into RUN.
//   - Without the macro, expect no response after 2*TIMEOUT cycles.

Source files
------------

// File: rtl/sc_mul_scheduler_if.sv
// rtl/sc_mul_scheduler_if.sv - requester, response and multiplier signals of sc_mul_scheduler
interface sc_mul_scheduler_if #(
    parameter int N_REQ     = 4,
    parameter int REG_WIDTH = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*REG_WIDTH-1:0] req_a;
    logic [N_REQ*REG_WIDTH-1:0] req_b;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IDW-1:0]             rsp_id;
    logic [REG_WIDTH-1:0]       rsp_x;
    logic                       rsp_err;
    logic                       mul_clr;
    logic [REG_WIDTH-1:0]       mul_a;
    logic [REG_WIDTH-1:0]       mul_b;
    logic                       mul_done;
    logic [REG_WIDTH-1:0]       mul_x;

    // scheduler side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_x,
        output req_ready, rsp_valid, rsp_id, rsp_x, rsp_err, mul_clr, mul_a, mul_b
    );

    // requester / multiplier side
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_x,
        input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_err, mul_clr, mul_a, mul_b
    );
endinterface

// File: rtl/sc_mul_scheduler.sv
// rtl/sc_mul_scheduler.sv - round-robin sharing of one stochastic multiplier (optional run timeout: SC_SCHED_TIMEOUT_EN)
module sc_mul_scheduler #(
    parameter int N_REQ     = 4,
    parameter int REG_WIDTH = 8,
    parameter int BSL       = 255,
    parameter int TIMEOUT   = BSL + 8
) (
    input  logic              clk,
    input  logic              rst,
    sc_mul_scheduler_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
`ifdef SC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
`else
    localparam int CW = 1;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("sc_mul_scheduler: N_REQ must be in 2..8");
    end
    if (TIMEOUT <= BSL + 2) begin : g_bad_timeout
        $error("sc_mul_scheduler: TIMEOUT must exceed the multiplier run length");
    end

    logic [1:0]           state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant;
    logic                 grant_found;
    logic [N_REQ-1:0]     ready;
    logic [IDW-1:0]       id_q;
    logic [REG_WIDTH-1:0] a_q;
    logic [REG_WIDTH-1:0] b_q;
    logic [REG_WIDTH-1:0] x_q;
    logic [CW-1:0]        cnt;
    logic                 done_ok;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IDW'(sum);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant       = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == S_IDLE && grant_found) ready[grant] = 1'b1;
    end

    // A done still high from the previous operation is seen while cnt is zero.
    assign done_ok = bus.mul_done && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        a_q   <= bus.req_a[grant*REG_WIDTH +: REG_WIDTH];
                        b_q   <= bus.req_b[grant*REG_WIDTH +: REG_WIDTH];
                        id_q  <= grant;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
`ifdef SC_SCHED_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
                    if (done_ok) begin
                        x_q   <= bus.mul_x;
                        state <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        x_q   <= '0;
                        state <= S_RESP;
                    end
`else
                    cnt <= 1'b1;
                    if (done_ok) begin
                        x_q   <= bus.mul_x;
                        state <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rr_ptr <= wrap_add(id_q, 1);
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SC_SCHED_TIMEOUT_EN
    logic err_q;

    // Done wins over a simultaneous timeout, so err is set only on the abort path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_RUN) begin
            if (done_ok) err_q <= 1'b0;
            else if (cnt == CW'(TIMEOUT - 1)) err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_x     = x_q;
    assign bus.mul_clr   = (state == S_CLR);
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
endmodule
